// File: rtl/mcont_chnbuf_wdata_fifo.sv
// Write-data staging FIFO for the memory-controller write path.
// Tracks accepted channel-buffer read strobes through a fixed-latency pipe,
// captures the returning read data into a small first-word-fall-through FIFO
// and hands it to the DDR write-data path with a valid/ready handshake.
// A credit output lets the sequencer strobe only when the data is sure to fit.
module mcont_chnbuf_wdata_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 3,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ext_buf_rd,
  input  logic                  ext_buf_rrefresh,
  input  logic [DATA_WIDTH-1:0] ext_buf_rdata,
  output logic                  rd_credit,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_valid,
  input  logic                  wdata_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [3:0]            inflight,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int SUM_W = ((LVL_W > 4) ? LVL_W : 4) + 1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [LVL_W-1:0]      LVL_ONE  = 1;
  localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
  localparam logic [SUM_W-1:0]      SUM_CAP  = SUM_W'(DEPTH);

  logic [RD_LATENCY-1:0] trk_q;
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             acc;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;
  logic [SUM_W-1:0] credit_sum;

  assign acc         = ext_buf_rd && !ext_buf_rrefresh;
  assign push        = trk_q[RD_LATENCY-1];
  assign wdata_valid = (fifo_level != '0);
  assign pop         = wdata_valid && wdata_ready;
  assign full        = (fifo_level == LVL_FULL);
  assign push_ok     = push && (!full || pop);
  assign drop        = push && !push_ok;

  // The head word is gated while empty so stale storage never shows on wdata.
  assign wdata = wdata_valid ? mem[rptr_q] : '0;

  // Credit counts stored words plus words still in the pipe; pops are not anticipated.
  assign credit_sum = SUM_W'(fifo_level) + SUM_W'(inflight);
  assign rd_credit  = (credit_sum < SUM_CAP);

  generate
    if (RD_LATENCY == 1) begin : g_trk_single
      // Single-stage tracker: the accepted strobe pushes on the very next cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trk_q <= '0;
        else        trk_q <= acc;
      end
    end else begin : g_trk_shift
      // Shift accepted strobes along so the last bit marks the data-return cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trk_q <= '0;
        else        trk_q <= {trk_q[RD_LATENCY-2:0], acc};
      end
    end
  endgenerate

  // Running population count of the tracker: one in per accept, one out per push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= '0;
    else        inflight <= inflight + {3'b000, acc} - {3'b000, push};
  end

  // Storage array has no reset; it is only read while the level says it holds data.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= ext_buf_rdata;
  end

  // Pointers and occupancy move together on accepted pushes and pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop)     rptr_q <= rptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky overflow on a dropped word; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_mcont_chnbuf_wdata_fifo.sv
// Testbench for mcont_chnbuf_wdata_fifo.
// A small channel-buffer model returns scheduled data RD_LATENCY cycles after
// each strobe; expected words are queued when strobes are issued and compared
// whenever the DUT hands a word over on the write-data handshake.
module tb_mcont_chnbuf_wdata_fifo;

  localparam int DW    = 64;
  localparam int LAT   = 3;
  localparam int DL2   = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ext_buf_rd;
  logic          ext_buf_rrefresh;
  logic [DW-1:0] ext_buf_rdata;
  logic          rd_credit;
  logic [DW-1:0] wdata;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DL2:0]  fifo_level;
  logic [3:0]    inflight;
  logic          overflow;
  logic          overflow_clr;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int rx_count = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ret_data [int];

  mcont_chnbuf_wdata_fifo #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (LAT),
    .DEPTH_LOG2 (DL2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ext_buf_rd       (ext_buf_rd),
    .ext_buf_rrefresh (ext_buf_rrefresh),
    .ext_buf_rdata    (ext_buf_rdata),
    .rd_credit        (rd_credit),
    .wdata            (wdata),
    .wdata_valid      (wdata_valid),
    .wdata_ready      (wdata_ready),
    .fifo_level       (fifo_level),
    .inflight         (inflight),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge and drive this cycle's defaults.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
    ext_buf_rd       = 1'b0;
    ext_buf_rrefresh = 1'b0;
    overflow_clr     = 1'b0;
    if (ret_data.exists(cyc)) begin
      ext_buf_rdata = ret_data[cyc];
      ret_data.delete(cyc);
    end else begin
      ext_buf_rdata = {$urandom(), $urandom()};
    end
  endtask

  // Strobe this cycle, schedule the buffer's return data, and queue it if it should be stored.
  task automatic applyStimulus(input logic refresh, input logic [DW-1:0] d, input bit expect_push);
    ext_buf_rd       = 1'b1;
    ext_buf_rrefresh = refresh;
    ret_data[cyc + LAT] = d;
    if (expect_push) exp_q.push_back(d);
  endtask

  // Scoreboard: every handshake must deliver the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst_n && wdata_valid && wdata_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_pop", 64'(exp_q.size()), 64'd1);
      end else begin
        checkOutput("sb_wdata", wdata, exp_q.pop_front());
        rx_count++;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int issued;
    int sent;
    int rx_start;
    int max_level;

    rst_n            = 1'b0;
    ext_buf_rd       = 1'b0;
    ext_buf_rrefresh = 1'b0;
    ext_buf_rdata    = '0;
    wdata_ready      = 1'b0;
    overflow_clr     = 1'b0;

    // Reset values while held in reset
    #2;
    checkOutput("rst_valid",    64'(wdata_valid), 64'd0);
    checkOutput("rst_credit",   64'(rd_credit),   64'd1);
    checkOutput("rst_wdata",    wdata,            64'd0);
    checkOutput("rst_level",    64'(fifo_level),  64'd0);
    checkOutput("rst_inflight", 64'(inflight),    64'd0);
    checkOutput("rst_overflow", 64'(overflow),    64'd0);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    repeat (3) nextCycle();

    // Latency: push lands RD_LATENCY cycles later, valid one cycle after that
    $display("[TB] latency test");
    applyStimulus(1'b0, 64'hA5A5_0000_0000_0001, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      nextCycle();
      checkOutput("lat_inflight",    64'(inflight),    64'd1);
      checkOutput("lat_valid_early", 64'(wdata_valid), 64'd0);
    end
    nextCycle();
    checkOutput("lat_valid",         64'(wdata_valid), 64'd1);
    checkOutput("lat_wdata",         wdata,            64'hA5A5_0000_0000_0001);
    checkOutput("lat_inflight_done", 64'(inflight),    64'd0);
    wdata_ready = 1'b1;
    nextCycle();
    checkOutput("lat_drained", 64'(fifo_level), 64'd0);
    wdata_ready = 1'b0;

    // Refresh filter: strobe during refresh is not tracked
    $display("[TB] refresh filter test");
    applyStimulus(1'b1, 64'hDEAD_BEEF_0000_0002, 1'b0);
    for (int i = 0; i < LAT + 3; i++) begin
      nextCycle();
      checkOutput("ref_inflight", 64'(inflight),    64'd0);
      checkOutput("ref_level",    64'(fifo_level),  64'd0);
      checkOutput("ref_valid",    64'(wdata_valid), 64'd0);
    end

    // Credit and full with the consumer stalled
    $display("[TB] credit and full test");
    issued = 0;
    for (int i = 0; i < 40; i++) begin
      checkOutput("full_credit", 64'(rd_credit), 64'(issued < DEPTH));
      if (rd_credit) begin
        applyStimulus(1'b0, 64'(issued + 1), 1'b1);
        issued++;
      end
      nextCycle();
    end
    checkOutput("full_accepted", 64'(issued),     64'd8);
    checkOutput("full_level",    64'(fifo_level), 64'd8);
    checkOutput("full_inflight", 64'(inflight),   64'd0);
    checkOutput("full_overflow", 64'(overflow),   64'd0);
    wdata_ready = 1'b1;
    checkOutput("full_credit_at_pop", 64'(rd_credit), 64'd0);
    nextCycle();
    checkOutput("full_credit_after_pop", 64'(rd_credit),  64'd1);
    checkOutput("full_level_after_pop",  64'(fifo_level), 64'd7);
    repeat (DEPTH) nextCycle();
    checkOutput("full_drained", 64'(fifo_level), 64'd0);
    checkOutput("full_sb_empty", 64'(exp_q.size()), 64'd0);
    wdata_ready = 1'b0;

    // Back-to-back streaming gated by credit
    $display("[TB] streaming test");
    wdata_ready = 1'b1;
    sent        = 0;
    rx_start    = rx_count;
    max_level   = 0;
    for (int i = 0; i < 2000 && (sent < 100 || exp_q.size() != 0); i++) begin
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (rd_credit && sent < 100) begin
        applyStimulus(1'b0, {48'h0, 16'(sent)}, 1'b1);
        sent++;
      end
      nextCycle();
    end
    checkOutput("stream_sent",      64'(sent),              64'd100);
    checkOutput("stream_received",  64'(rx_count - rx_start), 64'd100);
    checkOutput("stream_sb_empty",  64'(exp_q.size()),      64'd0);
    checkOutput("stream_overflow",  64'(overflow),          64'd0);
    checkOutput("stream_max_level", 64'(max_level > DEPTH), 64'd0);
    repeat (2) nextCycle();
    wdata_ready = 1'b0;

    // Forced overflow: ten strobes into an eight-word FIFO
    $display("[TB] forced overflow test");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 64'(256 + i), i <= DEPTH);
      nextCycle();
    end
    repeat (LAT + 1) nextCycle();
    checkOutput("ovf_flag",     64'(overflow),   64'd1);
    checkOutput("ovf_level",    64'(fifo_level), 64'd8);
    checkOutput("ovf_inflight", 64'(inflight),   64'd0);
    overflow_clr = 1'b1;
    nextCycle();
    checkOutput("ovf_clr_alone", 64'(overflow), 64'd0);
    applyStimulus(1'b0, 64'h1FF, 1'b0);
    repeat (LAT) nextCycle();
    overflow_clr = 1'b1;
    nextCycle();
    checkOutput("ovf_set_wins", 64'(overflow),   64'd1);
    checkOutput("ovf_level2",   64'(fifo_level), 64'd8);
    wdata_ready = 1'b1;
    repeat (DEPTH + 1) nextCycle();
    checkOutput("ovf_drained",  64'(fifo_level),   64'd0);
    checkOutput("ovf_sb_empty", 64'(exp_q.size()), 64'd0);
    wdata_ready  = 1'b0;
    overflow_clr = 1'b1;
    nextCycle();
    checkOutput("ovf_final_clr", 64'(overflow), 64'd0);

    // Reset mid-flight: stored and in-flight words are discarded
    $display("[TB] reset mid-flight test");
    applyStimulus(1'b0, 64'h201, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 64'h202, 1'b1);
    nextCycle();
    repeat (LAT) nextCycle();
    checkOutput("mid_level_pre", 64'(fifo_level), 64'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 64'(515 + i), 1'b1);
      nextCycle();
    end
    checkOutput("mid_inflight_pre", 64'(inflight), 64'd3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("mid_rst_valid",    64'(wdata_valid), 64'd0);
    checkOutput("mid_rst_level",    64'(fifo_level),  64'd0);
    checkOutput("mid_rst_inflight", 64'(inflight),    64'd0);
    checkOutput("mid_rst_credit",   64'(rd_credit),   64'd1);
    nextCycle();
    rst_n       = 1'b1;
    wdata_ready = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      nextCycle();
      checkOutput("mid_late_valid", 64'(wdata_valid), 64'd0);
    end
    checkOutput("mid_late_level",    64'(fifo_level), 64'd0);
    checkOutput("mid_late_inflight", 64'(inflight),   64'd0);
    wdata_ready = 1'b0;
    repeat (2) nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcont_chnbuf_wdata_fifo.md
Name: mcont_chnbuf_wdata_fifo

Overview:
- Downstream stage of the per-channel buffer read registers; it sits on the memory-controller write path.
- Captures the shared 64-bit channel-buffer read bus a fixed number of cycles after each accepted read strobe and queues the words in a small first-word-fall-through FIFO.
- Presents the queued words to the DDR write-data path with a valid/ready handshake.
- Issues a credit signal so the sequencer only strobes reads when there is guaranteed room for the returning data.

Parameters:
- DATA_WIDTH, 64, width of the read bus and of the FIFO words.
- RD_LATENCY, 3, cycles from an accepted ext_buf_rd to valid ext_buf_rdata (2 + per-channel buffer latency + 1); legal range 1..8.
- DEPTH_LOG2, 3, FIFO depth is 2^DEPTH_LOG2 words (default 8).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ext_buf_rd  in  1  read strobe to the channel buffers (same strobe the channel registers see).
- ext_buf_rrefresh  in  1  refresh in progress; a strobe issued with this high returns no data.
- ext_buf_rdata  in  DATA_WIDTH  merged read data from the channel buffer registers.
- rd_credit  out  1  high when one more strobe may be issued.
- wdata  out  DATA_WIDTH  head-of-FIFO word.
- wdata_valid  out  1  FIFO not empty.
- wdata_ready  in  1  consumer accepts wdata this cycle.
- fifo_level  out  DEPTH_LOG2+1  number of stored words, 0..2^DEPTH_LOG2.
- inflight  out  4  number of accepted strobes whose data has not yet been captured.
- overflow  out  1  sticky error flag.
- overflow_clr  in  1  synchronous clear for overflow.

Behaviour:
- Reset (rst_n low, asynchronous): pipe tracker, read and write pointers, fifo_level, inflight and overflow all go to 0. wdata_valid=0, rd_credit=1, wdata=0. Reset mid-operation discards in-flight strobes; data that returns afterwards is ignored.
- Accepted strobe: acc = ext_buf_rd && !ext_buf_rrefresh. Strobes issued during refresh are not tracked.
- Tracker: shift register of length RD_LATENCY. Bit 0 is loaded with acc; push = last bit. The accepted strobe at cycle N produces push at cycle N+RD_LATENCY, and ext_buf_rdata is sampled in that cycle.
- Pop: pop = wdata_valid && wdata_ready.
- Push acceptance:
  - Accepted when fifo_level < 2^DEPTH_LOG2, or when full and pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set to 1 on the next edge, and fifo_level is unchanged.
- fifo_level update: level + push_accepted - pop.
- Pointers: write and read pointers are DEPTH_LOG2-bit and wrap modulo depth.
- wdata / wdata_valid:
  - wdata_valid = (fifo_level != 0), taken from registers with no combinational path from wdata_ready.
  - wdata = mem[rptr]; it updates on the cycle after a pop.
  - Push into an empty FIFO gives wdata_valid=1 one cycle later (no bypass).
- inflight: equals the population count of the tracker register, i.e. +acc and -push per cycle. Saturation is impossible by construction.
- rd_credit: combinational from registers only, rd_credit = (fifo_level + inflight) < 2^DEPTH_LOG2.
  - Pops are not anticipated; this is conservative.
  - A strobe issued while rd_credit=0 is still tracked. Its push may overflow; overflow is the only detection and there is no other error action.
- overflow_clr: clears overflow on the next edge. If an overflow event occurs in the same cycle, set wins.
- No X propagation: mem contents are don't-care, but wdata must not be consumed while wdata_valid=0.

Test Plan:
- Latency check: reset, single strobe at cycle 10 with ext_buf_rdata=64'hA5A5_0000_0000_0001 at cycle 13 -> wdata_valid=1 at cycle 14 with wdata equal to that value; inflight is 1 during cycles 11..13.
- Refresh filter: strobe with ext_buf_rrefresh=1, data driven 3 cycles later -> inflight stays 0, fifo_level stays 0, wdata_valid=0.
- Credit and full (wdata_ready=0): issue strobes only while rd_credit=1 with incrementing data 1..N -> exactly 8 accepted; rd_credit=0 once fifo_level+inflight=8. Then raise wdata_ready -> words 1..8 pop in order and rd_credit returns on the cycle after the first pop.
- Back-to-back streaming: continuous strobes gated by rd_credit, wdata_ready=1, data = 16-bit counter values 0..99 -> all 100 words emerge in order, overflow=0, fifo_level never exceeds 8.
- Forced overflow: ignore rd_credit and issue 10 strobes with wdata_ready=0 -> words 9 and 10 dropped, overflow=1, fifo_level=8. Assert overflow_clr alone -> overflow=0 next cycle; assert overflow_clr in the same cycle as a dropped push -> overflow stays 1.
- Reset mid-flight: 3 strobes outstanding and 2 words stored, pulse rst_n low -> wdata_valid, fifo_level and inflight all read 0 immediately; late-returning data never appears on wdata.
